// File: rtl/dmem_pkg.sv
// Shared types for the data memory: access sizes and init/run states.
// Also a helper that maps an access size code to its byte count.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Load lane extract: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them to the full word width.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]                 size,
    input  logic                       uns,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [XLEN-1:0]            word,
    output logic [XLEN-1:0]            rdata
);

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic            sgn;

    always_comb begin
        sh   = word >> {off, 3'b000};
        keep = '1;
        sgn  = 1'b0;
        unique case (size_e'(size))
            SZ_B: begin
                keep = XLEN'(8'hFF);
                sgn  = sh[7];
            end
            SZ_H: begin
                keep = XLEN'(16'hFFFF);
                sgn  = sh[15];
            end
            SZ_W: begin
                keep = XLEN'(32'hFFFF_FFFF);
                sgn  = sh[31];
            end
            default: begin
                keep = '1;
                sgn  = 1'b0;
            end
        endcase
        rdata = (sh & keep) | ((!uns && sgn) ? ~keep : '0);
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable data memory with self-clearing init, byte-masked
// stores and a 1- or 2-stage load response pipeline.
module data_mem
    import dmem_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2048,
    parameter int READ_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            init_done
);

    localparam int NB    = XLEN / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int IDXW  = $clog2(DEPTH);
    localparam int WIDXW = 32 - OFFW;

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic            accept;
    logic [OFFW-1:0] off;
    logic [WIDXW-1:0] widx;
    logic [IDXW-1:0] idx;
    logic [3:0]      nbytes;
    logic            misal, oor, illegal, err;
    logic [NB-1:0]   be_base, be;
    logic [XLEN-1:0] wlanes;

    logic            mem_we;
    logic [IDXW-1:0] mem_idx;
    logic [NB-1:0]   mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rd_word;

    logic            s1_valid_d, s1_valid_q;
    logic            s1_err_d, s1_err_q;
    logic [1:0]      s1_size_d, s1_size_q;
    logic            s1_uns_d, s1_uns_q;
    logic [OFFW-1:0] s1_off_d, s1_off_q;
    logic [XLEN-1:0] s1_rdata_d, s1_rdata_q;
    logic [XLEN-1:0] al_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + IDXW'(1);
                if (ptr_q == IDXW'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Request decode: error classification, byte mask, replicated lanes
    always_comb begin
        off     = req_addr[OFFW-1:0];
        widx    = req_addr[31:OFFW];
        idx     = widx[IDXW-1:0];
        nbytes  = size_bytes(req_size);
        misal   = (off & OFFW'(nbytes - 4'd1)) != '0;
        oor     = widx >= WIDXW'(DEPTH);
        illegal = (req_size == 2'd3) && (XLEN == 32);
        err     = misal | oor | illegal;
        be_base = NB'((16'd1 << nbytes) - 16'd1);
        be      = be_base << off;
        wlanes  = req_wdata;
        unique case (size_e'(req_size))
            SZ_B:    wlanes = {NB{req_wdata[7:0]}};
            SZ_H:    wlanes = {(NB/2){req_wdata[15:0]}};
            SZ_W:    wlanes = {(XLEN/32){req_wdata[31:0]}};
            default: wlanes = req_wdata;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_RUN);
        init_done = (state_q == ST_RUN);
        accept    = req_valid && req_ready;
        mem_we    = 1'b0;
        mem_idx   = idx;
        mem_be    = be;
        mem_wdata = wlanes;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_idx   = ptr_q;
            mem_be    = '1;
            mem_wdata = '0;
        end else if (accept && req_we && !err) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) mem_q[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    assign rd_word = mem_q[idx];

    // Stores, errors and idle cycles carry a zero word so extension yields 0
    always_comb begin
        s1_valid_d = accept;
        s1_err_d   = accept && err;
        s1_size_d  = req_size;
        s1_uns_d   = req_unsigned;
        s1_off_d   = off;
        s1_rdata_d = (accept && !req_we && !err) ? rd_word : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_size_q  <= '0;
            s1_uns_q   <= 1'b0;
            s1_off_q   <= '0;
            s1_rdata_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_size_q  <= s1_size_d;
            s1_uns_q   <= s1_uns_d;
            s1_off_q   <= s1_off_d;
            s1_rdata_q <= s1_rdata_d;
        end
    end

    dmem_align #(
        .XLEN (XLEN)
    ) u_align (
        .size  (s1_size_q),
        .uns   (s1_uns_q),
        .off   (s1_off_q),
        .word  (s1_rdata_q),
        .rdata (al_rdata)
    );

    if (READ_LAT == 2) begin : g_lat2
        logic            s2_valid_q;
        logic            s2_err_q;
        logic [XLEN-1:0] s2_rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_err_q   <= 1'b0;
                s2_rdata_q <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_err_q   <= s1_err_q;
                s2_rdata_q <= al_rdata;
            end
        end

        assign resp_valid = s2_valid_q;
        assign resp_err   = s2_err_q;
        assign resp_rdata = s2_rdata_q;
    end else begin : g_lat1
        assign resp_valid = s1_valid_q;
        assign resp_err   = s1_err_q;
        assign resp_rdata = al_rdata;
    end

endmodule
